// File: rtl/coef_quantizer_if.sv
// Coefficient stream toward the entropy coder, plus block resync and
// reciprocal-table programming signals for the quantizer.
interface coef_quantizer_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int COEF_W = 16
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     blk_restart;
    logic                     tbl_we;
    logic [5:0]               tbl_addr;
    logic [COEF_W-1:0]        tbl_data;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output in_data, in_valid, blk_restart, tbl_we, tbl_addr, tbl_data, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, blk_restart, tbl_we, tbl_addr, tbl_data, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/coef_quantizer.sv
// Per-position coefficient quantizer: multiplies |x| by a programmable reciprocal,
// rounds half away from zero, re-applies the sign and saturates. Two-stage pipeline.
module coef_quantizer #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int COEF_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    coef_quantizer_if.slave bus
);

    localparam int NCOEF = 64;
    // Q = 16 default step
    localparam logic [COEF_W-1:0] RECIP_RST = {3'b000, 1'b1, {(COEF_W-4){1'b0}}};
    localparam logic [DATA_W+COEF_W:0] HALF_LSB =
        {{(DATA_W+1){1'b0}}, 1'b1, {(COEF_W-1){1'b0}}};
    localparam logic [DATA_W:0] POS_LIM = {{(DATA_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [DATA_W:0] NEG_LIM = {{(DATA_W-OUT_W+1){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

    function automatic logic [DATA_W:0] round_mag(input logic [DATA_W-1:0] mag,
                                                   input logic [COEF_W-1:0] recip);
        logic [DATA_W+COEF_W:0] prod;
        prod = {{(COEF_W+1){1'b0}}, mag} * {{(DATA_W+1){1'b0}}, recip};
        prod = prod + HALF_LSB;
        return prod[DATA_W+COEF_W:COEF_W];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_q(input logic neg,
                                                      input logic [DATA_W:0] q);
        logic [OUT_W-1:0] low;
        low = q[OUT_W-1:0];
        if (!neg)
            return (q > POS_LIM) ? {1'b0, {(OUT_W-1){1'b1}}} : low;
        else if (q >= NEG_LIM)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return -low;
    endfunction

    logic                     advance;
    logic                     accept;
    logic [5:0]               idx;
    logic [COEF_W-1:0]        tbl [NCOEF];
    logic [DATA_W-1:0]        mag_in;

    logic                     vld_p1;
    logic                     neg_p1;
    logic                     last_p1;
    logic [DATA_W-1:0]        mag_p1;
    logic [COEF_W-1:0]        recip_p1;

    logic                     vld_p2;
    logic                     last_p2;
    logic signed [OUT_W-1:0]  data_p2;

    assign advance       = !vld_p2 || bus.out_ready;
    assign accept        = bus.in_valid && advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_p2;
    assign bus.out_last  = last_p2;
    assign bus.out_data  = data_p2;

    // Unsigned magnitude keeps |-2^(DATA_W-1)| exact.
    assign mag_in = bus.in_data[DATA_W-1] ? $unsigned(-bus.in_data) : $unsigned(bus.in_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) tbl[i] <= RECIP_RST;
        end else if (bus.tbl_we) begin
            tbl[bus.tbl_addr] <= bus.tbl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               idx <= '0;
        else if (bus.blk_restart) idx <= '0;
        else if (accept)          idx <= idx + 6'd1;
    end

    // ---- stage 1: sign, magnitude, reciprocal lookup, block-last flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_p1 <= 1'b0;
        else if (advance) vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            neg_p1   <= bus.in_data[DATA_W-1];
            mag_p1   <= mag_in;
            recip_p1 <= tbl[idx];
            last_p1  <= (idx == 6'd63);
        end
    end

    // ---- stage 2: multiply, round, sign, saturate ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            data_p2 <= '0;
        end else if (advance) begin
            vld_p2  <= vld_p1;
            last_p2 <= vld_p1 && last_p1;
            if (vld_p1) data_p2 <= sat_q(neg_p1, round_mag(mag_p1, recip_p1));
        end
    end

endmodule

// File: tb/tb_coef_quantizer.sv
// Directed bench for coef_quantizer: reset, rounding, saturation, block indexing,
// back-pressure, block restart and table write collision.
module tb_coef_quantizer;

    logic clk;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    logic signed [15:0] stim [$];
    logic signed [7:0]  got_d [$];
    logic               got_l [$];

    coef_quantizer_if #(.DATA_W(16), .OUT_W(8), .COEF_W(16)) bus ();

    coef_quantizer #(.DATA_W(16), .OUT_W(8), .COEF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
        end
    end

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.blk_restart = 1'b0;
        bus.tbl_we      = 1'b0;
        bus.tbl_addr    = '0;
        bus.tbl_data    = '0;
        bus.out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_d.delete();
        got_l.delete();
    endtask

    task automatic tbl_write(input logic [5:0] a, input logic [15:0] v);
        bus.tbl_we   = 1'b1;
        bus.tbl_addr = a;
        bus.tbl_data = v;
        @(posedge clk);
        #1 bus.tbl_we = 1'b0;
    endtask

    // Streams stim[] back to back with out_ready held high.
    task automatic run_stream();
        bus.out_ready = 1'b1;
        foreach (stim[i]) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim[i];
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int g;
        g = 0;
        while (got_d.size() < n && g < 300) begin
            @(posedge clk);
            #1 g++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(1000 + i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        nvec++; if (bus.out_data !== 8'sd0) begin nerr++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
        nvec++; if (bus.out_last !== 1'b0) begin nerr++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got_d.delete();
        got_l.delete();
        repeat (4) @(posedge clk);
        #1;
        nvec++; if (got_d.size() !== 0) begin nerr++; $display("FAIL reset_discard: got %0d outputs want 0", got_d.size()); end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sd100;
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL lat_c0: got %b want 0", bus.out_valid); end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL lat_c1: got %b want 0", bus.out_valid); end
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL lat_c2_valid: got %b want 1", bus.out_valid); end
        nvec++; if (bus.out_data !== 8'sd6) begin nerr++; $display("FAIL lat_c2_data: got %0d want 6", bus.out_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rounding();
        logic signed [7:0] exp_d [3];
        exp_d = '{-8'sd3, 8'sd1, 8'sd0};
        do_reset();
        stim = '{-16'sd40, 16'sd8, 16'sd7};
        run_stream();
        wait_out(3);
        nvec++; if (got_d.size() !== 3) begin nerr++; $display("FAIL round_count: got %0d want 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== 1'b0) begin
                nerr++; $display("FAIL round_%0d: got %0d/%b want %0d/0", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [7:0] exp_d [3];
        exp_d = '{8'sd127, -8'sd128, 8'sd0};
        do_reset();
        for (int a = 0; a < 64; a++) tbl_write(6'(a), 16'hFFFF);
        stim = '{16'sd32767, -16'sd32768, 16'sd0};
        run_stream();
        wait_out(3);
        nvec++; if (got_d.size() !== 3) begin nerr++; $display("FAIL sat_count: got %0d want 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            nvec++;
            if (got_d[i] !== exp_d[i]) begin
                nerr++; $display("FAIL sat_%0d: got %0d want %0d", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_block_index();
        logic signed [7:0] e;
        do_reset();
        tbl_write(6'd63, 16'hFFFF);
        stim.delete();
        for (int i = 0; i < 65; i++) stim.push_back(16'sd20);
        run_stream();
        wait_out(65);
        nvec++; if (got_d.size() !== 65) begin nerr++; $display("FAIL blk_count: got %0d want 65", got_d.size()); end
        for (int i = 0; i < 65 && i < got_d.size(); i++) begin
            e = (i == 63) ? 8'sd20 : 8'sd1;
            nvec++;
            if (got_d[i] !== e || got_l[i] !== (i == 63)) begin
                nerr++; $display("FAIL blk_%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 63));
            end
        end
    endtask

    task automatic test_backpressure();
        int                sent;
        logic              prev_stall;
        logic signed [7:0] prev_data;
        do_reset();
        sent       = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 80 && got_d.size() < 10; cyc++) begin
            bus.out_ready = cyc[0];
            bus.in_valid  = (sent < 10);
            bus.in_data   = 16'(16 * (sent + 1));
            @(negedge clk);
            nvec++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                nerr++; $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, bus.in_ready, (!bus.out_valid || bus.out_ready));
            end
            if (prev_stall) begin
                nvec++;
                if (bus.out_data !== prev_data || bus.out_valid !== 1'b1) begin
                    nerr++; $display("FAIL bp_hold cyc %0d: got %0d want %0d", cyc, bus.out_data, prev_data);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_out(10);
        nvec++; if (got_d.size() !== 10) begin nerr++; $display("FAIL bp_count: got %0d want 10", got_d.size()); end
        for (int i = 0; i < 10 && i < got_d.size(); i++) begin
            nvec++;
            if (got_d[i] !== 8'(i + 1) || got_l[i] !== 1'b0) begin
                nerr++; $display("FAIL bp_order_%0d: got %0d want %0d", i, got_d[i], i + 1);
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_data     = 16'sd16;
            bus.blk_restart = (i == 4);
            @(posedge clk);
            #1;
        end
        bus.blk_restart = 1'b0;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(16'sd16);
        run_stream();
        wait_out(69);
        nvec++; if (got_d.size() !== 69) begin nerr++; $display("FAIL rst_count: got %0d want 69", got_d.size()); end
        for (int i = 0; i < 69 && i < got_d.size(); i++) begin
            nvec++;
            if (got_d[i] !== 8'sd1 || got_l[i] !== (i == 68)) begin
                nerr++; $display("FAIL restart_%0d: got %0d/%b want 1/%b", i, got_d[i], got_l[i], (i == 68));
            end
        end
    endtask

    task automatic test_collision();
        logic signed [7:0] e;
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'sd160;
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = 6'd0;
        bus.tbl_data  = 16'hFFFF;
        @(posedge clk);
        #1 bus.tbl_we = 1'b0;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(16'sd160);
        run_stream();
        wait_out(65);
        nvec++; if (got_d.size() !== 65) begin nerr++; $display("FAIL coll_count: got %0d want 65", got_d.size()); end
        for (int i = 0; i < 65 && i < got_d.size(); i++) begin
            e = (i == 64) ? 8'sd127 : 8'sd10;
            if (i == 64) e = 8'sd127;
            nvec++;
            if (got_d[i] !== e || got_l[i] !== (i == 63)) begin
                nerr++; $display("FAIL coll_%0d: got %0d/%b want %0d/%b", i, got_d[i], got_l[i], e, (i == 63));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_rounding();
        test_saturation();
        test_block_index();
        test_backpressure();
        test_restart();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/coef_quantizer.md
Name: coef_quantizer

Overview:
- Downstream stage of the dynamic scaling block in the DCT datapath.
- Consumes scaled DCT coefficients in 8x8 block order (64 per block).
- Divides each coefficient by a per-position quantization step using a programmable 64-entry reciprocal table, rounds, and saturates.
- Emits quantized coefficients with a block-last marker under a valid/ready handshake toward the entropy coder.

Parameters:
bit_width, 16, width of signed input coefficient (matches scaling stage output)
out_width, 8, width of signed quantized output
recip_width, 16, width of unsigned reciprocal table entry (Q0.recip_width fraction)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  bit_width  signed scaled coefficient
in_valid  input  1  in_data valid
in_ready  output  1  stage can accept in_data this cycle
blk_restart  input  1  force coefficient index to 0 (block resync)
tbl_we  input  1  reciprocal table write enable
tbl_addr  input  6  table write address (coefficient position 0..63)
tbl_data  input  recip_width  reciprocal value, round(2^recip_width / Q)
out_data  output  out_width  signed quantized coefficient
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  out_data is coefficient 63 of its block

Behaviour:
- Reset: asynchronous on rst_n low. Outputs and state on reset:
  - out_data=0, out_valid=0, out_last=0.
  - Both pipeline valids=0, coefficient index=0.
  - Every table entry = 2^(recip_width-4), i.e. 4096 (Q=16).
  - Reset mid-block discards all in-flight data.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - Input accepted when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - When advance=0, all pipeline registers, including out_data, hold their values.
- Pipeline (latency 2 cycles, accept to out_valid, with no stall):
  - Stage 1 registers: sign(in_data), |in_data| (bit_width bits, unsigned, so |-2^(bit_width-1)| is exact), table[idx], last = (idx==63).
  - Stage 2: product = mag * recip; q = (product + 2^(recip_width-1)) >> recip_width, giving round-half-away-from-zero on magnitude.
  - Stage 2 then applies the sign and saturates to [-2^(out_width-1), 2^(out_width-1)-1] before registering out_data and out_last.
  - Zero input yields 0 (never -0 issues).
- Throughput: one coefficient per cycle when out_ready is held high.
- Coefficient index (6 bits):
  - Increments on each accepted input; wraps 63 -> 0.
  - blk_restart=1 sets idx=0 next cycle. If blk_restart and an accepted input coincide, the accepted input uses the current idx and the next idx=0.
- Table:
  - Written on tbl_we regardless of handshake state.
  - Same-cycle write and stage-1 read of the same address: stage 1 captures the old value; the new value applies from the next accepted coefficient.
  - Table is not readable externally.
- out_last:
  - Asserted with out_valid for the coefficient whose stage-1 idx was 63.
  - Held with out_data during stalls.

Test Plan:
- Reset values: hold rst_n=0 mid-stream -> out_valid=0, in_ready=1. Then feed in_data=100 with the default table -> out_data=6 exactly 2 cycles after accept.
- Rounding: with default 4096, in_data=-40 -> out_data=-3; in_data=8 -> out_data=1; in_data=7 -> out_data=0.
- Saturation: write all entries to 65535. in_data=32767 -> out_data=127; in_data=-32768 -> out_data=-128.
- Block indexing:
  - Write table[63]=65535, others 4096.
  - Stream 64 coefficients of value 20 with out_ready=1 -> outputs 1 (x63) then 20.
  - out_last=1 only on the 64th output.
  - The 65th input maps to idx 0.
- Back-pressure: stream 10 values with out_ready toggling 1/0 every cycle -> in_ready tracks advance, no loss or duplication, output order equals input order, out_data stable while stalled.
- Restart and table collision:
  - Assert blk_restart after 5 accepted inputs -> next output's out_last occurs after 64 more inputs.
  - Write table[idx] in the same cycle as the accept -> that coefficient uses the old value, the next block uses the new one.
